// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings and per-state control decode for the multicycle MIPS controller
// Contents: state_t (FETCH1=0 .. ADDIWR=14), opcode/funct constants, alucont codes,
//           aluop / alusrcb / pcsource select codes, ctrl_t bundle and state_ctrl().
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH1  = 4'd0,
    FETCH2  = 4'd1,
    FETCH3  = 4'd2,
    FETCH4  = 4'd3,
    DECODE  = 4'd4,
    MEMADR  = 4'd5,
    LBRD    = 4'd6,
    LBWR    = 4'd7,
    SBWR    = 4'd8,
    RTYPEEX = 4'd9,
    RTYPEWR = 4'd10,
    BEQEX   = 4'd11,
    JEX     = 4'd12,
    ADDIEX  = 4'd13,
    ADDIWR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // alu_en marks states that drive alucont; elsewhere alucont reads 000.
  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memwrite;
    logic [3:0] irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       alu_en;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH1, FETCH2, FETCH3, FETCH4: begin
        c.irwrite = 4'(4'b0001 << s[1:0]);
        c.alusrcb = SRCB_ONE;
        c.alu_en  = 1'b1;
        c.pcwrite = 1'b1;
      end
      DECODE: begin
        c.alusrcb = SRCB_IMMSH;
        c.alu_en  = 1'b1;
      end
      MEMADR, LBRD, SBWR, ADDIEX, ADDIWR: begin
        // Address / write data come straight off the ALU, so selects are held.
        c.alusrca  = 1'b1;
        c.alusrcb  = SRCB_IMM;
        c.alu_en   = 1'b1;
        c.iord     = (s == LBRD) || (s == SBWR);
        c.memwrite = (s == SBWR);
        c.regwrite = (s == ADDIWR);
      end
      LBWR: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      RTYPEEX, RTYPEWR: begin
        c.alusrca  = 1'b1;
        c.alusrcb  = SRCB_B;
        c.alu_en   = 1'b1;
        c.aluop    = ALUOP_FUNCT;
        c.regdst   = (s == RTYPEWR);
        c.regwrite = (s == RTYPEWR);
      end
      BEQEX: begin
        c.alusrca     = 1'b1;
        c.alusrcb     = SRCB_B;
        c.alu_en      = 1'b1;
        c.aluop       = ALUOP_SUB;
        c.pcsource    = PCSRC_ALUOUT;
        c.pcwritecond = 1'b1;
      end
      JEX: begin
        c.pcsource = PCSRC_JUMP;
        c.pcwrite  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps aluop and funct to the 3-bit ALU operation code
// Ports: aluop[1:0] (00 add, 01 sub, 10 funct), funct[5:0], alucont[2:0].
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucont
);

  always_comb begin
    alucont = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucont = ALU_ADD;
      ALUOP_SUB: alucont = ALU_SUB;
      default: begin
        case (funct)
          FUNCT_SUB: alucont = ALU_SUB;
          FUNCT_AND: alucont = ALU_AND;
          FUNCT_OR:  alucont = ALU_OR;
          FUNCT_SLT: alucont = ALU_SLT;
          default:   alucont = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - control FSM for the 8-bit multicycle MIPS core
// Inputs: clk, reset (sync, active-high), op[5:0], funct[5:0], zero.
// Outputs: pcen, iord, memwrite, irwrite[3:0], regdst, memtoreg, regwrite,
//          alusrca, alusrcb[1:0], alucont[2:0], pcsource[1:0].
module multicycle_controller
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic [3:0] irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucont,
  output logic [1:0] pcsource
);

  state_t     state;
  state_t     state_next;
  ctrl_t      ctrl;
  logic [2:0] alucont_dec;
  logic       active;

  always_comb begin
    state_next = FETCH1;
    case (state)
      FETCH1:  state_next = FETCH2;
      FETCH2:  state_next = FETCH3;
      FETCH3:  state_next = FETCH4;
      FETCH4:  state_next = DECODE;
      DECODE: begin
        case (op)
          OP_LB, OP_SB: state_next = MEMADR;
          OP_RTYPE:     state_next = RTYPEEX;
          OP_BEQ:       state_next = BEQEX;
          OP_J:         state_next = JEX;
          OP_ADDI:      state_next = ADDIEX;
          default:      state_next = FETCH1;
        endcase
      end
      MEMADR:  state_next = (op == OP_LB) ? LBRD : SBWR;
      LBRD:    state_next = LBWR;
      RTYPEEX: state_next = RTYPEWR;
      ADDIEX:  state_next = ADDIWR;
      default: state_next = FETCH1;
    endcase
  end

  // Control strobes are registered alongside the state so each state's
  // outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH1;
      ctrl  <= state_ctrl(FETCH1);
    end else begin
      state <= state_next;
      ctrl  <= state_ctrl(state_next);
    end
  end

  alu_decoder u_alu_decoder (
    .aluop   (ctrl.aluop),
    .funct   (funct),
    .alucont (alucont_dec)
  );

  // Reset gates every output combinationally so an aborted instruction
  // cannot strobe anything during the reset cycle itself.
  assign active   = ~reset;
  assign pcen     = active & (ctrl.pcwrite | (ctrl.pcwritecond & zero));
  assign iord     = active & ctrl.iord;
  assign memwrite = active & ctrl.memwrite;
  assign irwrite  = active ? ctrl.irwrite : 4'b0000;
  assign regdst   = active & ctrl.regdst;
  assign memtoreg = active & ctrl.memtoreg;
  assign regwrite = active & ctrl.regwrite;
  assign alusrca  = active & ctrl.alusrca;
  assign alusrcb  = active ? ctrl.alusrcb : 2'b00;
  assign alucont  = (active && ctrl.alu_en) ? alucont_dec : 3'b000;
  assign pcsource = active ? ctrl.pcsource : 2'b00;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, iord, memwrite, regdst, memtoreg, regwrite, alusrca;
  logic [3:0] irwrite;
  logic [1:0] alusrcb, pcsource;
  logic [2:0] alucont;

  int vectors = 0;
  int miscompares = 0;

  multicycle_controller dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .funct    (funct),
    .zero     (zero),
    .pcen     (pcen),
    .iord     (iord),
    .memwrite (memwrite),
    .irwrite  (irwrite),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .regwrite (regwrite),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .alucont  (alucont),
    .pcsource (pcsource)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] got_vec();
    return {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
            alusrca, alusrcb, alucont, pcsource};
  endfunction

  function automatic int cpi(input logic [5:0] o);
    case (o)
      6'b100000: return 8;
      6'b101000, 6'b000000, 6'b001000: return 7;
      6'b000100, 6'b000010: return 6;
      default: return 5;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for cycle k (0-based) of an instruction.
  function automatic logic [17:0] exp_vec(input logic [5:0] o, input logic [5:0] f,
                                          input logic z, input int k);
    logic e_pcen, e_iord, e_mw, e_rd, e_m2r, e_rw, e_sa;
    logic [3:0] e_ir;
    logic [1:0] e_sb, e_ps;
    logic [2:0] e_alu;
    {e_pcen, e_iord, e_mw, e_rd, e_m2r, e_rw, e_sa} = '0;
    e_ir = 4'b0000; e_sb = 2'b00; e_ps = 2'b00; e_alu = 3'b000;
    if (k < 4) begin
      e_ir = 4'(1 << k); e_sb = 2'b01; e_alu = 3'b010; e_pcen = 1'b1;
    end else if (k == 4) begin
      e_sb = 2'b11; e_alu = 3'b010;
    end else if (o == 6'b100000 || o == 6'b101000 || o == 6'b001000) begin
      if (o == 6'b100000 && k == 7) begin
        e_m2r = 1'b1; e_rw = 1'b1;
      end else begin
        e_sa = 1'b1; e_sb = 2'b10; e_alu = 3'b010;
        if (k == 6 && o != 6'b001000) e_iord = 1'b1;
        if (k == 6 && o == 6'b101000) e_mw = 1'b1;
        if (k == 6 && o == 6'b001000) e_rw = 1'b1;
      end
    end else if (o == 6'b000000) begin
      e_sa = 1'b1; e_sb = 2'b00; e_alu = funct_alu(f);
      if (k == 6) begin e_rd = 1'b1; e_rw = 1'b1; end
    end else if (o == 6'b000100) begin
      e_sa = 1'b1; e_alu = 3'b110; e_ps = 2'b01; e_pcen = z;
    end else if (o == 6'b000010) begin
      e_ps = 2'b10; e_pcen = 1'b1;
    end
    return {e_pcen, e_iord, e_mw, e_ir, e_rd, e_m2r, e_rw, e_sa, e_sb, e_alu, e_ps};
  endfunction

  // zmode: 0/1 drives zero constant, 2 randomises it every cycle.
  task automatic run_instr(input string name, input logic [5:0] o,
                           input logic [5:0] f, input int zmode);
    logic [17:0] g, e;
    op = o; funct = f;
    for (int k = 0; k < cpi(o); k++) begin
      zero = (zmode == 2) ? 1'($urandom_range(1)) : 1'(zmode);
      @(negedge clk);
      g = got_vec();
      e = exp_vec(o, f, zero, k);
      vectors++;
      if (g !== e) begin
        miscompares++;
        $display("FAIL %s op=%b funct=%b cycle=%0d zero=%b got=%h expected=%h",
                 name, o, f, k, zero, g, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; op = 6'b000000; funct = 6'b000000; zero = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      op = 6'($urandom);
      @(negedge clk);
      vectors++;
      if (got_vec() !== 18'h0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle=%0d got=%h expected=%h", i, got_vec(), 18'h0);
      end
      @(posedge clk);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_lb();
    run_instr("lb", OP_LB, 6'($urandom), 2);
    run_instr("lb_b2b", OP_LB, 6'($urandom), 2);
  endtask

  task automatic test_rtype();
    logic [5:0] fl [3] = '{6'b100010, 6'b101010, 6'b111111};
    foreach (fl[i]) run_instr("rtype", OP_RTYPE, fl[i], 2);
  endtask

  task automatic test_beq();
    run_instr("beq_taken", OP_BEQ, 6'($urandom), 1);
    run_instr("beq_not_taken", OP_BEQ, 6'($urandom), 0);
  endtask

  task automatic test_undefined();
    run_instr("undef_op", 6'b111111, 6'($urandom), 2);
    run_instr("after_undef", OP_J, 6'($urandom), 2);
  endtask

  task automatic test_reset_in_sbwr();
    logic [17:0] e;
    op = OP_SB; funct = 6'($urandom);
    for (int k = 0; k < 6; k++) begin
      zero = 1'($urandom_range(1));
      @(negedge clk);
      e = exp_vec(OP_SB, funct, zero, k);
      vectors++;
      if (got_vec() !== e) begin
        miscompares++;
        $display("FAIL sb_prefix cycle=%0d got=%h expected=%h", k, got_vec(), e);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1; zero = 1'b1;
    @(negedge clk);
    vectors++;
    if (memwrite !== 1'b0 || got_vec() !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_in_sbwr memwrite=%b got=%h expected=%h", memwrite, got_vec(), 18'h0);
    end
    @(posedge clk); #1 reset = 1'b0;
    run_instr("after_sbwr_reset", OP_ADDI, 6'($urandom), 2);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [6] = '{OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI};
    logic [5:0] fns [6] = '{FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLT, 6'b000111};
    logic [5:0] o, f;
    for (int n = 0; n < 40; n++) begin
      o = ($urandom_range(3) == 0) ? 6'($urandom) : ops[$urandom_range(5)];
      f = ($urandom_range(3) == 0) ? 6'($urandom) : fns[$urandom_range(5)];
      run_instr("random", o, f, 2);
    end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_rtype();
    test_beq();
    test_undefined();
    test_reset_in_sbwr();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the 8-bit multicycle MIPS core. Consumes `op`, `funct` and `zero` from the datapath and drives every datapath control strobe: PC enable, address select, memory write, byte-wise IR load, register-file and ALU operand selects, ALU control and next-PC select. Sequences the byte-wise instruction fetch, decode, execute, memory and writeback states for lb, sb, R-type, beq, j and addi.

## Interface
- No parameters.
- `clk` in 1: single clock; all state changes occur on the rising edge.
- `reset` in 1: synchronous, active-high.
- `op` in 6: `instr[31:26]` from the datapath.
- `funct` in 6: `instr[5:0]` from the datapath.
- `zero` in 1: ALU zero flag, combinational from the datapath.
- `pcen` out 1: PC register enable, defined as `pcwrite | (pcwritecond & zero)`.
- `iord` out 1: memory address select; 0 selects PC, 1 selects ALU result.
- `memwrite` out 1: memory write strobe.
- `irwrite` out 4: one-hot IR byte load; bit n loads `instr[8n+7:8n]`.
- `regdst` out 1: write-address select; 0 selects rt, 1 selects rd.
- `memtoreg` out 1: write-data select; 0 selects ALU result, 1 selects memory data register.
- `regwrite` out 1: register-file write enable.
- `alusrca` out 1: ALU operand A select; 0 selects PC, 1 selects register A.
- `alusrcb` out 2: ALU operand B select; 00 selects B, 01 selects constant 1, 10 selects imm, 11 selects imm<<2.
- `alucont` out 3: ALU operation; 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `pcsource` out 2: next-PC select; 00 selects ALU result, 01 selects the ALU-out flop, 10 selects the jump target.

## Operation
- The state register is 4 bits. States: FETCH1–4, DECODE, MEMADR, LBRD, LBWR, SBWR, RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR.
- Outputs are Moore, decoded from state. The only exception is `pcen`, which also depends on `zero`.
- Any output not listed for a state is 0.
- FETCHn (n = 1..4): `irwrite`=one-hot bit n-1, `iord`=0, `alusrca`=0, `alusrcb`=01, `alucont`=add, `pcsource`=00, `pcwrite`=1.
  - FETCHn advances to FETCHn+1; FETCH4 advances to DECODE.
- DECODE: `alusrca`=0, `alusrcb`=11, add. This precomputes the branch target into the ALU-out flop. Next state by `op`:
  - 100000 (lb) or 101000 (sb) → MEMADR
  - 000000 (R-type) → RTYPEEX
  - 000100 (beq) → BEQEX
  - 000010 (j) → JEX
  - 001000 (addi) → ADDIEX
  - any other opcode → FETCH1 (executes as a nop)
- MEMADR: `alusrca`=1, `alusrcb`=10, add. Next state is LBRD for lb, SBWR for sb.
- LBRD: same ALU selects as MEMADR, plus `iord`=1. The address path is combinational from the ALU, so the operand selects must be held. Next: LBWR.
- LBWR: `regdst`=0, `memtoreg`=1, `regwrite`=1. Next: FETCH1.
- SBWR: ALU selects as MEMADR, `iord`=1, `memwrite`=1. Next: FETCH1.
- RTYPEEX: `alusrca`=1, `alusrcb`=00, `alucont` from the funct decode. Next: RTYPEWR.
- RTYPEWR: ALU selects as RTYPEEX (held, because write data comes from the combinational ALU), `regdst`=1, `memtoreg`=0, `regwrite`=1. Next: FETCH1.
- Funct decode:
  - 100000 → add
  - 100010 → sub
  - 100100 → and
  - 100101 → or
  - 101010 → slt
  - any other funct → add
- BEQEX: `alusrca`=1, `alusrcb`=00, sub, `pcsource`=01, `pcwritecond`=1. Next: FETCH1.
- JEX: `pcsource`=10, `pcwrite`=1. Next: FETCH1.
- ADDIEX: `alusrca`=1, `alusrcb`=10, add. Next: ADDIWR.
- ADDIWR: ALU selects as ADDIEX, `regdst`=0, `memtoreg`=0, `regwrite`=1. Next: FETCH1.

## Timing
- Reset:
  - While `reset`=1, every output is forced to 0, including `pcen` regardless of `zero`.
  - The state register loads FETCH1 on the reset edge.
  - Reset asserted in any state, mid-instruction, aborts that instruction. No write strobe is issued in the reset cycle.
- The first cycle after `reset` falls is FETCH1.
- Cycles per instruction: lb 8, sb 7, R-type 7, addi 7, beq 6, j 6, undefined opcode 5.
- PC and ALU timing:
  - PC increments by 1 in each FETCH cycle, so it equals the instruction address + 4 at DECODE.
  - The ALU-out flop captures PC+4+(imm<<2) at the end of DECODE.
- beq: `pcen` in BEQEX follows `zero` combinationally within the cycle. Not taken means the PC is unchanged.
- No handshake exists: memory is single-cycle, and the FSM advances every cycle.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - state encodings (FETCH1=0 … ADDIWR=14)
  - opcode constants
  - funct constants
  - `alucont` codes
  - `alusrcb` and `pcsource` select codes
- Sub-module `alu_decoder`: combinational; inputs `aluop`[1:0] (00 add, 01 sub, 10 funct) and `funct`; output `alucont`.
- The top level contains the state register, next-state logic, output decode and the `pcen` gating.

## Test plan
- Reset held for 3 cycles, then released:
  - all outputs are 0 during reset;
  - the next 4 cycles show `irwrite` 0001, 0010, 0100, 1000 with `pcen`=1 and `alusrcb`=01;
  - the following cycle is DECODE with `alusrcb`=11.
- `op`=100000 (lb):
  - LBRD shows `iord`=1, `alusrcb`=10;
  - LBWR shows `memtoreg`=1, `regwrite`=1, `regdst`=0;
  - total 8 cycles, then FETCH1.
- `op`=000000 (R-type):
  - `funct` 100010, 101010 and 111111 give `alucont` 110, 111 and 010 respectively;
  - RTYPEWR shows `regdst`=1, `regwrite`=1.
- `op`=000100 (beq):
  - `zero`=1 in BEQEX gives `pcen`=1, `pcsource`=01;
  - `zero`=0 gives `pcen`=0;
  - total 6 cycles.
- Boundary cases:
  - `op`=111111 returns to FETCH1 after DECODE with no write strobe;
  - `reset` asserted in SBWR gives `memwrite`=0 that cycle and FETCH1 next.
